// File: rtl/divs16_8_if.sv
// rtl/divs16_8_if.sv - start/busy/done handshake and result bundle for divs16_8
interface divs16_8_if;
    logic        start;
    logic [15:0] a;
    logic [7:0]  b;
    logic        busy;
    logic        done;
    logic [7:0]  q;
    logic [7:0]  r;
    logic        ovf;
    logic        dz;

    modport master (
        output start, a, b,
        input  busy, done, q, r, ovf, dz
    );

    modport slave (
        input  start, a, b,
        output busy, done, q, r, ovf, dz
    );
endinterface

// File: rtl/divs16_8.sv
// rtl/divs16_8.sv - sequential signed 16/8 restoring divider, one quotient bit per cycle
module divs16_8 (
    input  logic      clk,
    input  logic      rst,
    divs16_8_if.slave bus
);
    typedef enum logic [1:0] {S_IDLE, S_CALC, S_FIX} state_t;

    state_t      r_state;
    state_t      w_next;
    logic [3:0]  r_cnt;
    logic [7:0]  r_rem;
    logic [15:0] r_quo;
    logic [7:0]  r_dvs;
    logic        r_sa;
    logic        r_sb;
    logic        r_dzp;
    logic        r_done;
    logic [7:0]  r_q;
    logic [7:0]  r_r;
    logic        r_ovf;
    logic        r_dz;

    logic [15:0] w_abs_a;
    logic [7:0]  w_abs_b;
    logic [8:0]  w_shift;
    logic        w_ge;
    logic [7:0]  w_rem_next;
    logic        w_neg;
    logic        w_ovf;
    logic [7:0]  w_q;
    logic [7:0]  w_r;

    assign w_abs_a = bus.a[15] ? (~bus.a + 16'd1) : bus.a;
    assign w_abs_b = bus.b[7]  ? (~bus.b + 8'd1)  : bus.b;

    // The kept remainder is always below |b| <= 128, so the low byte of the
    // subtraction is exact whenever the trial succeeds.
    assign w_shift    = {r_rem, r_quo[15]};
    assign w_ge       = (w_shift >= {1'b0, r_dvs});
    assign w_rem_next = w_ge ? (w_shift[7:0] - r_dvs) : w_shift[7:0];

    assign w_neg = r_sa ^ r_sb;
    assign w_ovf = w_neg ? (r_quo > 16'd128) : (r_quo > 16'd127);
    assign w_q   = w_ovf ? (w_neg ? 8'h80 : 8'h7F)
                         : (w_neg ? (~r_quo[7:0] + 8'd1) : r_quo[7:0]);
    assign w_r   = r_sa ? (~r_rem + 8'd1) : r_rem;

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (bus.start) begin
                    w_next = (bus.b == 8'h00) ? S_FIX : S_CALC;
                end
            end
            S_CALC: begin
                if (r_cnt == 4'd15) begin
                    w_next = S_FIX;
                end
            end
            S_FIX:   w_next = S_IDLE;
            default: w_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            r_cnt   <= 4'd0;
            r_rem   <= 8'd0;
            r_quo   <= 16'd0;
            r_dvs   <= 8'd0;
            r_sa    <= 1'b0;
            r_sb    <= 1'b0;
            r_dzp   <= 1'b0;
            r_done  <= 1'b0;
            r_q     <= 8'd0;
            r_r     <= 8'd0;
            r_ovf   <= 1'b0;
            r_dz    <= 1'b0;
        end else begin
            r_state <= w_next;
            r_done  <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    if (bus.start) begin
                        r_sa  <= bus.a[15];
                        r_sb  <= bus.b[7];
                        r_quo <= w_abs_a;
                        r_dvs <= w_abs_b;
                        r_rem <= 8'd0;
                        r_cnt <= 4'd0;
                        r_dzp <= (bus.b == 8'h00);
                    end
                end
                S_CALC: begin
                    r_rem <= w_rem_next;
                    r_quo <= {r_quo[14:0], w_ge};
                    r_cnt <= r_cnt + 4'd1;
                end
                S_FIX: begin
                    r_done <= 1'b1;
                    if (r_dzp) begin
                        r_q   <= 8'h00;
                        r_r   <= 8'h00;
                        r_ovf <= 1'b0;
                        r_dz  <= 1'b1;
                    end else begin
                        r_q   <= w_q;
                        r_r   <= w_r;
                        r_ovf <= w_ovf;
                        r_dz  <= 1'b0;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.busy = (r_state != S_IDLE);
    assign bus.done = r_done;
    assign bus.q    = r_q;
    assign bus.r    = r_r;
    assign bus.ovf  = r_ovf;
    assign bus.dz   = r_dz;
endmodule

// File: tb/tb_divs16_8.sv
// tb/tb_divs16_8.sv - randomized and directed self-checking bench for divs16_8
module tb_divs16_8;
    logic clk;
    logic rst;
    int   checks;
    int   errors;

    divs16_8_if bus ();

    divs16_8 dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        logic        dz;
        int          lat;
    } vec_t;

    // Reference: plain integer division (truncating) and modulo (dividend sign).
    function automatic void model(input logic [15:0] a, input logic [7:0] b,
                                  output logic [7:0] q, output logic [7:0] r,
                                  output logic ovf, output logic dz);
        int sa;
        int sb;
        int tq;
        int tr;
        sa = $signed(a);
        sb = $signed(b);
        if (sb == 0) begin
            q = 8'h00; r = 8'h00; ovf = 1'b0; dz = 1'b1;
        end else begin
            tq  = sa / sb;
            tr  = sa % sb;
            dz  = 1'b0;
            ovf = (tq > 127) || (tq < -128);
            q   = ovf ? ((tq > 0) ? 8'h7F : 8'h80) : tq[7:0];
            r   = tr[7:0];
        end
    endfunction

    task automatic run_div(input logic [15:0] a, input logic [7:0] b,
                           output int lat, output logic busy0,
                           output logic [7:0] q, output logic [7:0] r,
                           output logic ovf, output logic dz);
        int k;
        @(negedge clk);
        bus.a     = a;
        bus.b     = b;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        busy0 = bus.busy;
        k = 0;
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        lat = bus.done ? k : -1;
        q   = bus.q;
        r   = bus.r;
        ovf = bus.ovf;
        dz  = bus.dz;
    endtask

    task automatic test_reset();
        rst       = 1'b1;
        bus.start = 1'b1;
        bus.a     = 16'h0064;
        bus.b     = 8'h07;
        repeat (3) @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.q, bus.r, bus.ovf, bus.dz} !== 20'h0) begin
            errors++;
            $display("FAIL reset_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b, want all zero",
                     bus.busy, bus.done, bus.q, bus.r, bus.ovf, bus.dz);
        end
        bus.start = 1'b0;
        rst = 1'b0;
        @(negedge clk);
        checks++;
        if (bus.busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_idle_busy: got %b want 0", bus.busy);
        end
    endtask

    task automatic test_directed();
        vec_t        vt[$];
        int          lat;
        logic        busy0;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        logic        dz;
        vt.push_back('{16'h0064, 8'h07, 8'h0E, 8'h02, 1'b0, 1'b0, 17});
        vt.push_back('{16'hFF9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b0, 17});
        vt.push_back('{16'hFF9C, 8'hF9, 8'h0E, 8'hFE, 1'b0, 1'b0, 17});
        vt.push_back('{16'h3F01, 8'h7F, 8'h7F, 8'h00, 1'b0, 1'b0, 17});
        vt.push_back('{16'h3F01, 8'h81, 8'h81, 8'h00, 1'b0, 1'b0, 17});
        vt.push_back('{16'h0001, 8'hFF, 8'hFF, 8'h00, 1'b0, 1'b0, 17});
        vt.push_back('{16'hC080, 8'h7F, 8'h80, 8'h00, 1'b0, 1'b0, 17});
        vt.push_back('{16'h3F81, 8'h7F, 8'h7F, 8'h01, 1'b1, 1'b0, 17});
        vt.push_back('{16'h8000, 8'hFF, 8'h7F, 8'h00, 1'b1, 1'b0, 17});
        vt.push_back('{16'h8000, 8'h80, 8'h7F, 8'h00, 1'b1, 1'b0, 17});
        vt.push_back('{16'h0080, 8'h80, 8'hFF, 8'h00, 1'b0, 1'b0, 17});
        vt.push_back('{16'h1234, 8'h00, 8'h00, 8'h00, 1'b0, 1'b1, 1});
        foreach (vt[i]) begin
            run_div(vt[i].a, vt[i].b, lat, busy0, q, r, ovf, dz);
            checks++;
            if (busy0 !== 1'b1 || lat != vt[i].lat) begin
                errors++;
                $display("FAIL dir_timing[%0d]: got busy=%b latency=%0d, want busy=1 latency=%0d",
                         i, busy0, lat, vt[i].lat);
            end
            checks++;
            if ({q, r, ovf, dz} !== {vt[i].q, vt[i].r, vt[i].ovf, vt[i].dz}) begin
                errors++;
                $display("FAIL dir_result[%0d] a=%h b=%h: got q=%h r=%h ovf=%b dz=%b, want q=%h r=%h ovf=%b dz=%b",
                         i, vt[i].a, vt[i].b, q, r, ovf, dz, vt[i].q, vt[i].r, vt[i].ovf, vt[i].dz);
            end
            @(negedge clk);
            checks++;
            if (bus.done !== 1'b0 || bus.busy !== 1'b0 || bus.q !== q || bus.r !== r) begin
                errors++;
                $display("FAIL dir_hold[%0d]: got done=%b busy=%b q=%h r=%h, want done=0 busy=0 q=%h r=%h",
                         i, bus.done, bus.busy, bus.q, bus.r, q, r);
            end
        end
    endtask

    task automatic test_random();
        int          lat;
        logic        busy0;
        logic [15:0] a;
        logic [7:0]  b;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        logic        dz;
        logic [7:0]  eq;
        logic [7:0]  er;
        logic        eovf;
        logic        edz;
        for (int i = 0; i < 200; i++) begin
            a = 16'($urandom);
            b = ($urandom_range(0, 15) == 0) ? 8'h00 : 8'($urandom);
            model(a, b, eq, er, eovf, edz);
            run_div(a, b, lat, busy0, q, r, ovf, dz);
            checks++;
            if (lat != (edz ? 1 : 17) || {q, r, ovf, dz} !== {eq, er, eovf, edz}) begin
                errors++;
                $display("FAIL rand[%0d] a=%h b=%h: got lat=%0d q=%h r=%h ovf=%b dz=%b, want lat=%0d q=%h r=%h ovf=%b dz=%b",
                         i, a, b, lat, q, r, ovf, dz, edz ? 1 : 17, eq, er, eovf, edz);
            end
        end
    endtask

    task automatic test_mul_inverse();
        int          lat;
        logic        busy0;
        int          x;
        int          y;
        int          p;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        logic        dz;
        logic [7:0]  xb;
        for (int i = 0; i < 60; i++) begin
            x = $urandom_range(0, 255) - 128;
            do y = $urandom_range(0, 255) - 128; while (y == 0);
            p  = x * y;
            xb = x[7:0];
            run_div(p[15:0], y[7:0], lat, busy0, q, r, ovf, dz);
            checks++;
            if ({q, r, ovf, dz} !== {xb, 8'h00, 1'b0, 1'b0}) begin
                errors++;
                $display("FAIL mulinv[%0d] %0d*%0d: got q=%h r=%h ovf=%b dz=%b, want q=%h r=00 ovf=0 dz=0",
                         i, x, y, q, r, ovf, dz, xb);
            end
        end
    endtask

    task automatic test_back_to_back();
        int k;
        int n_done;
        @(negedge clk);
        bus.a     = 16'h0064;
        bus.b     = 8'h07;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        k = 0;
        while (!bus.done && k < 40) begin
            bus.a = 16'($urandom);
            bus.b = 8'($urandom);
            @(negedge clk);
            k++;
        end
        checks++;
        if (k != 17 || bus.q !== 8'h0E || bus.r !== 8'h02) begin
            errors++;
            $display("FAIL b2b_first: got lat=%0d q=%h r=%h, want lat=17 q=0e r=02", k, bus.q, bus.r);
        end
        bus.a = 16'hFF9C;
        bus.b = 8'hF9;
        @(negedge clk);
        k = 1;
        checks++;
        if (bus.busy !== 1'b1 || bus.done !== 1'b0) begin
            errors++;
            $display("FAIL b2b_accept: got busy=%b done=%b, want busy=1 done=0", bus.busy, bus.done);
        end
        while (!bus.done && k < 40) begin
            @(negedge clk);
            k++;
        end
        bus.start = 1'b0;
        checks++;
        if (k != 18 || bus.q !== 8'h0E || bus.r !== 8'hFE) begin
            errors++;
            $display("FAIL b2b_second: got spacing=%0d q=%h r=%h, want spacing=18 q=0e r=fe", k, bus.q, bus.r);
        end
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done || bus.busy) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL b2b_no_queue: got %0d busy/done cycles, want 0", n_done);
        end
    endtask

    task automatic test_abort();
        int          lat;
        logic        busy0;
        logic [7:0]  q;
        logic [7:0]  r;
        logic        ovf;
        logic        dz;
        int          n_done;
        run_div(16'h3F81, 8'h7F, lat, busy0, q, r, ovf, dz);
        @(negedge clk);
        bus.a     = 16'h0064;
        bus.b     = 8'h07;
        bus.start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (8) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if ({bus.busy, bus.done, bus.q, bus.r, bus.ovf, bus.dz} !== 20'h0) begin
            errors++;
            $display("FAIL abort_outputs: got busy=%b done=%b q=%h r=%h ovf=%b dz=%b, want all zero",
                     bus.busy, bus.done, bus.q, bus.r, bus.ovf, bus.dz);
        end
        rst = 1'b0;
        n_done = 0;
        for (int i = 0; i < 25; i++) begin
            @(negedge clk);
            if (bus.done) n_done++;
        end
        checks++;
        if (n_done != 0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses, want 0", n_done);
        end
        run_div(16'hFF9C, 8'h07, lat, busy0, q, r, ovf, dz);
        checks++;
        if (lat != 17 || q !== 8'hF2 || r !== 8'hFE) begin
            errors++;
            $display("FAIL abort_recover: got lat=%0d q=%h r=%h, want lat=17 q=f2 r=fe", lat, q, r);
        end
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        checks    = 0;
        errors    = 0;
        rst       = 1'b1;
        bus.start = 1'b0;
        bus.a     = 16'h0;
        bus.b     = 8'h0;
        test_reset();
        test_directed();
        test_random();
        test_mul_inverse();
        test_back_to_back();
        test_abort();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
